// File: rtl/sgm_pkg.sv
// Shared types and default constants for the SGM path scheduler and its raster tracker.
package sgm_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_GAP        = 2'd1,
        ST_LINE       = 2'd2
    } raster_state_t;

    localparam int IMG_WIDTH_DEF      = 1280;
    localparam int HALF_IMG_WIDTH_DEF = 640;
    localparam int ROW_WIDTH_DEF      = 10;
    localparam int COL_WIDTH_DEF      = 11;
    localparam int P_BITS_DEF         = 8;
    localparam int P1_DEFAULT_DEF     = 15;
    localparam int P2_DEFAULT_DEF     = 100;

endpackage

// File: rtl/raster_tracker.sv
// Frame/line FSM with row/column counters and a sticky over-length line flag.
// Exposes next-state values so the top can register strobes in the same cycle as row/col.
module raster_tracker
    import sgm_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int ROW_WIDTH = ROW_WIDTH_DEF,
    parameter int COL_WIDTH = COL_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 de_in,
    input  logic                 v_sync_in,
    output logic                 vs_rise,
    output logic                 de_next,
    output logic [ROW_WIDTH-1:0] row_next,
    output logic [COL_WIDTH-1:0] col_next,
    output logic [ROW_WIDTH-1:0] row,
    output logic [COL_WIDTH-1:0] col,
    output logic                 line_err
);

    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 1);

    raster_state_t        state_reg, state_next;
    logic                 vs_prev_reg;
    logic [ROW_WIDTH-1:0] row_reg;
    logic [COL_WIDTH-1:0] col_reg;
    logic                 line_err_reg, line_err_next;

    assign vs_rise = v_sync_in && !vs_prev_reg;

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        line_err_next = line_err_reg;
        de_next       = 1'b0;
        if (vs_rise) begin
            // Frame start wins over whatever the line was doing.
            state_next    = ST_GAP;
            row_next      = '0;
            col_next      = '0;
            line_err_next = 1'b0;
        end else begin
            case (state_reg)
                ST_GAP: begin
                    if (de_in) begin
                        state_next = ST_LINE;
                        col_next   = '0;
                        de_next    = 1'b1;
                    end
                end
                ST_LINE: begin
                    if (de_in) begin
                        de_next = 1'b1;
                        if (col_reg == COL_LAST) begin
                            line_err_next = 1'b1;
                        end else begin
                            col_next = col_reg + 1'b1;
                        end
                    end else begin
                        state_next = ST_GAP;
                        col_next   = '0;
                        if (row_reg != '1) begin
                            row_next = row_reg + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_WAIT_FRAME;
            vs_prev_reg  <= 1'b0;
            row_reg      <= '0;
            col_reg      <= '0;
            line_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            vs_prev_reg  <= v_sync_in;
            row_reg      <= row_next;
            col_reg      <= col_next;
            line_err_reg <= line_err_next;
        end
    end

    assign row      = row_reg;
    assign col      = col_reg;
    assign line_err = line_err_reg;

endmodule

// File: rtl/sgm_path_scheduler.sv
// Control strobes for the SGM path cost calculators plus frame-synchronous P1/P2 penalty registers.
module sgm_path_scheduler
    import sgm_pkg::*;
#(
    parameter int IMG_WIDTH      = IMG_WIDTH_DEF,
    parameter int HALF_IMG_WIDTH = HALF_IMG_WIDTH_DEF,
    parameter int ROW_WIDTH      = ROW_WIDTH_DEF,
    parameter int COL_WIDTH      = COL_WIDTH_DEF,
    parameter int P_BITS         = P_BITS_DEF,
    parameter int P1_DEFAULT     = P1_DEFAULT_DEF,
    parameter int P2_DEFAULT     = P2_DEFAULT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 de_in,
    input  logic                 h_sync_in,
    input  logic                 v_sync_in,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [P_BITS-1:0]    cfg_p1,
    input  logic [P_BITS-1:0]    cfg_p2,
    output logic [P_BITS-1:0]    p1,
    output logic [P_BITS-1:0]    p2,
    output logic [ROW_WIDTH-1:0] row,
    output logic [COL_WIDTH-1:0] col,
    output logic                 de_half,
    output logic                 de_half_ext,
    output logic                 beg_horizontal,
    output logic                 beg_top,
    output logic                 beg_diag_l2r,
    output logic                 beg_diag_r2l,
    output logic                 cfg_pending,
    output logic                 line_err
);

    localparam logic [COL_WIDTH-1:0] COL_HALF = COL_WIDTH'(HALF_IMG_WIDTH);
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 1);

    logic                 vs_rise;
    logic                 de_next;
    logic [ROW_WIDTH-1:0] row_next;
    logic [COL_WIDTH-1:0] col_next;

    // Horizontal sync carries no information the scheduler needs.
    logic unused_h_sync;
    assign unused_h_sync = h_sync_in;

    raster_tracker #(
        .IMG_WIDTH (IMG_WIDTH),
        .ROW_WIDTH (ROW_WIDTH),
        .COL_WIDTH (COL_WIDTH)
    ) u_raster_tracker (
        .clk       (clk),
        .rst       (rst),
        .de_in     (de_in),
        .v_sync_in (v_sync_in),
        .vs_rise   (vs_rise),
        .de_next   (de_next),
        .row_next  (row_next),
        .col_next  (col_next),
        .row       (row),
        .col       (col),
        .line_err  (line_err)
    );

    // Strobes are decoded from the tracker's next values so they line up with row/col.
    logic de_half_next, beg_h_next, beg_top_next, beg_r2l_next;

    assign de_half_next = de_next && (col_next >= COL_HALF);
    assign beg_h_next   = de_next && (col_next == COL_HALF);
    assign beg_top_next = de_half_next && (row_next == '0);
    assign beg_r2l_next = de_half_next && ((col_next == COL_LAST) || (row_next == '0));

    logic de_half_reg, de_half_ext_reg, beg_h_reg, beg_top_reg, beg_l2r_reg, beg_r2l_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_half_reg     <= 1'b0;
            de_half_ext_reg <= 1'b0;
            beg_h_reg       <= 1'b0;
            beg_top_reg     <= 1'b0;
            beg_l2r_reg     <= 1'b0;
            beg_r2l_reg     <= 1'b0;
        end else begin
            de_half_reg     <= de_half_next;
            de_half_ext_reg <= de_half_next || de_half_reg;
            beg_h_reg       <= beg_h_next;
            beg_top_reg     <= beg_top_next;
            beg_l2r_reg     <= beg_h_next || beg_top_next;
            beg_r2l_reg     <= beg_r2l_next;
        end
    end

    assign de_half        = de_half_reg;
    assign de_half_ext    = de_half_ext_reg;
    assign beg_horizontal = beg_h_reg;
    assign beg_top        = beg_top_reg;
    assign beg_diag_l2r   = beg_l2r_reg;
    assign beg_diag_r2l   = beg_r2l_reg;

    // Penalty shadow: one write may wait for the next frame start; p2 never drops below p1.
    logic [P_BITS-1:0] p1_reg, p2_reg, shadow_p1_reg, shadow_p2_reg;
    logic [P_BITS-1:0] cfg_p2_clamped;
    logic              pending_reg, ready_reg;
    logic              capture;

    assign capture        = cfg_valid && !pending_reg;
    assign cfg_p2_clamped = (cfg_p2 < cfg_p1) ? cfg_p1 : cfg_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_reg        <= P_BITS'(P1_DEFAULT);
            p2_reg        <= P_BITS'(P2_DEFAULT);
            shadow_p1_reg <= P_BITS'(P1_DEFAULT);
            shadow_p2_reg <= P_BITS'(P2_DEFAULT);
            pending_reg   <= 1'b0;
            ready_reg     <= 1'b1;
        end else if (vs_rise) begin
            if (capture) begin
                p1_reg <= cfg_p1;
                p2_reg <= cfg_p2_clamped;
            end else if (pending_reg) begin
                p1_reg <= shadow_p1_reg;
                p2_reg <= shadow_p2_reg;
            end
            pending_reg <= 1'b0;
            ready_reg   <= 1'b1;
        end else if (capture) begin
            shadow_p1_reg <= cfg_p1;
            shadow_p2_reg <= cfg_p2_clamped;
            pending_reg   <= 1'b1;
            ready_reg     <= 1'b0;
        end
    end

    assign p1          = p1_reg;
    assign p2          = p2_reg;
    assign cfg_pending = pending_reg;
    assign cfg_ready   = ready_reg;

endmodule

// File: tb/tb_sgm_path_scheduler.sv
// Scoreboard bench for sgm_path_scheduler: a pixel-position model predicts every output one cycle ahead.
module tb_sgm_path_scheduler;

    logic       clk = 1'b0;
    logic       rst, de_in, h_sync_in, v_sync_in, cfg_valid;
    logic [7:0] cfg_p1, cfg_p2;
    logic       cfg_ready, cfg_pending, line_err;
    logic [7:0] p1, p2;
    logic [9:0] row;
    logic [10:0] col;
    logic       de_half, de_half_ext, beg_horizontal, beg_top, beg_diag_l2r, beg_diag_r2l;

    always #5 clk = ~clk;

    sgm_path_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .de_in          (de_in),
        .h_sync_in      (h_sync_in),
        .v_sync_in      (v_sync_in),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_p1         (cfg_p1),
        .cfg_p2         (cfg_p2),
        .p1             (p1),
        .p2             (p2),
        .row            (row),
        .col            (col),
        .de_half        (de_half),
        .de_half_ext    (de_half_ext),
        .beg_horizontal (beg_horizontal),
        .beg_top        (beg_top),
        .beg_diag_l2r   (beg_diag_l2r),
        .beg_diag_r2l   (beg_diag_r2l),
        .cfg_pending    (cfg_pending),
        .line_err       (line_err)
    );

    typedef struct packed {
        logic [7:0]  p1;
        logic [7:0]  p2;
        logic [9:0]  row;
        logic [10:0] col;
        logic        de_half;
        logic        de_half_ext;
        logic        beg_horizontal;
        logic        beg_top;
        logic        beg_diag_l2r;
        logic        beg_diag_r2l;
        logic        cfg_pending;
        logic        cfg_ready;
        logic        line_err;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state, kept in frame/pixel terms.
    bit         m_in_frame, m_in_line, m_err, m_prev_vs, m_pend, m_prev_dh;
    int         m_x, m_row;
    logic [7:0] m_p1, m_p2, m_sh1, m_sh2;

    function automatic exp_t model_step(input bit r, input bit de, input bit vs, input bit cv,
                                        input logic [7:0] c1, input logic [7:0] c2);
        exp_t e;
        bit rise, cap, de_eff;
        logic [7:0] c2c;
        int colv;
        e = '0;
        if (r) begin
            m_in_frame = 0; m_in_line = 0; m_err = 0; m_prev_vs = 0; m_pend = 0; m_prev_dh = 0;
            m_x = 0; m_row = 0; m_p1 = 8'd15; m_p2 = 8'd100; m_sh1 = 8'd15; m_sh2 = 8'd100;
            e.p1 = 8'd15; e.p2 = 8'd100; e.cfg_ready = 1'b1;
            return e;
        end
        rise = vs && !m_prev_vs;
        m_prev_vs = vs;
        cap = cv && !m_pend;
        c2c = (c2 < c1) ? c1 : c2;
        if (rise) begin
            if (cap) begin m_p1 = c1; m_p2 = c2c; end
            else if (m_pend) begin m_p1 = m_sh1; m_p2 = m_sh2; end
            m_pend = 0;
        end else if (cap) begin
            m_sh1 = c1; m_sh2 = c2c; m_pend = 1;
        end
        de_eff = 0;
        if (rise) begin
            m_in_frame = 1; m_in_line = 0; m_x = 0; m_row = 0; m_err = 0;
        end else if (m_in_frame) begin
            if (de) begin
                if (m_in_line) m_x++;
                else begin m_in_line = 1; m_x = 0; end
                if (m_x > 1279) m_err = 1;
                de_eff = 1;
            end else if (m_in_line) begin
                m_in_line = 0;
                if (m_row < 1023) m_row++;
            end
        end
        colv = de_eff ? ((m_x > 1279) ? 1279 : m_x) : 0;
        e.p1 = m_p1;
        e.p2 = m_p2;
        e.row = 10'(m_row);
        e.col = 11'(colv);
        e.de_half = de_eff && (colv >= 640);
        e.de_half_ext = e.de_half || m_prev_dh;
        m_prev_dh = e.de_half;
        e.beg_horizontal = de_eff && (colv == 640);
        e.beg_top = (m_row == 0) && e.de_half;
        e.beg_diag_l2r = e.beg_horizontal || e.beg_top;
        e.beg_diag_r2l = ((colv == 1279) || (m_row == 0)) && e.de_half;
        e.cfg_pending = m_pend;
        e.cfg_ready = !m_pend;
        e.line_err = m_err;
        return e;
    endfunction

    int bh_cnt, bt_cnt, br1_cnt, ext_tail_cnt;

    task automatic step(input bit r, input bit de, input bit vs, input bit cv,
                        input logic [7:0] c1, input logic [7:0] c2);
        exp_t e, o;
        rst = r; de_in = de; v_sync_in = vs; h_sync_in = !de;
        cfg_valid = cv; cfg_p1 = c1; cfg_p2 = c2;
        sb_q.push_back(model_step(r, de, vs, cv, c1, c2));
        @(posedge clk);
        #1;
        o = {p1, p2, row, col, de_half, de_half_ext, beg_horizontal, beg_top,
             beg_diag_l2r, beg_diag_r2l, cfg_pending, cfg_ready, line_err};
        e = sb_q.pop_front();
        check_eq("outputs", 64'(o), 64'(e));
        if (beg_horizontal) bh_cnt++;
        if (beg_top) bt_cnt++;
        if (beg_diag_r2l && row == 10'd1) br1_cnt++;
        if (de_half_ext && !de_half) ext_tail_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'd0, 8'd0);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 8'd0, 8'd0);
        idle(8);
    endtask

    task automatic vsync();
        step(0, 0, 1, 0, 8'd0, 8'd0);
        step(0, 0, 1, 0, 8'd0, 8'd0);
        idle(3);
    endtask

    initial begin
        rst = 1'b1; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
        cfg_valid = 1'b0; cfg_p1 = '0; cfg_p2 = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'd0, 8'd0);
        check_eq("rst_p1", 64'(p1), 64'd15);
        check_eq("rst_p2", 64'(p2), 64'd100);
        check_eq("rst_ready", 64'(cfg_ready), 64'd1);

        // de before any frame start must be ignored
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'd0, 8'd0);
        check_eq("wait_col", 64'(col), 64'd0);
        check_eq("wait_de_half", 64'(de_half), 64'd0);

        vsync();
        bh_cnt = 0; bt_cnt = 0; br1_cnt = 0; ext_tail_cnt = 0;
        line(1280);
        check_eq("row_after_line0", 64'(row), 64'd1);
        line(1280);
        check_eq("bh_count", 64'(bh_cnt), 64'd2);
        check_eq("bt_count", 64'(bt_cnt), 64'd640);
        check_eq("br_row1_count", 64'(br1_cnt), 64'd1);
        check_eq("ext_tail_count", 64'(ext_tail_cnt), 64'd2);
        check_eq("row_after_line1", 64'(row), 64'd2);

        // mid-frame penalty write waits for the next frame
        step(0, 0, 0, 1, 8'd20, 8'd120);
        check_eq("cfg_ready_low", 64'(cfg_ready), 64'd0);
        line(100);
        check_eq("p1_held", 64'(p1), 64'd15);
        check_eq("p2_held", 64'(p2), 64'd100);
        step(0, 0, 1, 0, 8'd0, 8'd0);
        check_eq("p1_applied", 64'(p1), 64'd20);
        check_eq("p2_applied", 64'(p2), 64'd120);
        check_eq("cfg_ready_high", 64'(cfg_ready), 64'd1);
        idle(3);

        // write coinciding with frame start bypasses the shadow, with p2 clamped up to p1
        step(0, 0, 1, 1, 8'd50, 8'd30);
        check_eq("bypass_p1", 64'(p1), 64'd50);
        check_eq("bypass_p2", 64'(p2), 64'd50);
        check_eq("bypass_pending", 64'(cfg_pending), 64'd0);
        idle(3);

        // over-length line
        for (int i = 0; i < 1300; i++) step(0, 1, 0, 0, 8'd0, 8'd0);
        check_eq("long_col", 64'(col), 64'd1279);
        check_eq("long_err", 64'(line_err), 64'd1);
        idle(4);
        vsync();
        check_eq("err_cleared", 64'(line_err), 64'd0);

        // reset mid-line at col 700 of row 3 discards a pending write
        line(1280);
        line(1280);
        step(0, 0, 0, 1, 8'd77, 8'd88);
        line(1280);
        for (int i = 0; i < 701; i++) step(0, 1, 0, 0, 8'd0, 8'd0);
        check_eq("pre_rst_row", 64'(row), 64'd3);
        check_eq("pre_rst_col", 64'(col), 64'd700);
        step(1, 1, 0, 0, 8'd0, 8'd0);
        check_eq("rst_col", 64'(col), 64'd0);
        check_eq("rst_pending", 64'(cfg_pending), 64'd0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 8'd0, 8'd0);
        check_eq("post_rst_de_half", 64'(de_half), 64'd0);
        idle(2);
        vsync();
        check_eq("discarded_p1", 64'(p1), 64'd15);
        line(700);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sgm_path_scheduler.md
# sgm_path_scheduler

Control and configuration sequencer for the SGM stereo datapath. It tracks raster position from the incoming video timing and produces the registered control strobes that drive the path cost calculators: half-image data enable, extended data enable and the per-direction path-beginning pulses. It also owns the P1/P2 penalty registers, which are written through a valid/ready port and applied only at frame boundaries so one frame never mixes penalties. It sits beside the cost pipeline in the SGM top level and replaces the ad-hoc comparators there.

## Interface
- IMG_WIDTH, 1280: active pixels per line of the side-by-side image.
- HALF_IMG_WIDTH, 640: column where the aggregated half begins.
- ROW_WIDTH, 10: row counter width.
- COL_WIDTH, 11: column counter width.
- P_BITS, 8: penalty width.
- P1_DEFAULT, 15: P1 reset value.
- P2_DEFAULT, 100: P2 reset value.

Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.

- clk  in  1  system/pixel clock.
- rst  in  1  synchronous active-high reset.
- de_in  in  1  video data enable.
- h_sync_in  in  1  horizontal sync (pass-through timing only).
- v_sync_in  in  1  vertical sync; its rising edge marks frame start.
- cfg_valid  in  1  penalty write request.
- cfg_ready  out  1  high when the shadow register is free.
- cfg_p1  in  P_BITS  requested P1.
- cfg_p2  in  P_BITS  requested P2.
- p1, p2  out  P_BITS  active penalties, stable for the whole frame.
- row  out  ROW_WIDTH  current row.
- col  out  COL_WIDTH  current column.
- de_half  out  1  de within the right half (col ≥ HALF_IMG_WIDTH).
- de_half_ext  out  1  de_half OR de_half delayed by one cycle.
- beg_horizontal  out  1  col == HALF_IMG_WIDTH.
- beg_top  out  1  row == 0 and de_half.
- beg_diag_l2r  out  1  beg_horizontal OR beg_top.
- beg_diag_r2l  out  1  (col == IMG_WIDTH−1 OR row == 0) and de_half.
- cfg_pending  out  1  shadow holds an unapplied write.
- line_err  out  1  sticky flag: a line exceeded IMG_WIDTH.

## Operation
- FSM states:
  - WAIT_FRAME: the reset state. de_in is ignored. A v_sync_in rising edge moves to GAP.
  - GAP: de_in low inside a frame. de_in high moves to LINE.
  - LINE: de_in high. de_in low moves to GAP and increments row.
- A v_sync_in rising edge in any state clears row and col to 0, clears line_err, applies pending penalties and enters GAP.
- col increments on every de_in cycle in LINE and clears on entry to GAP.
  - If col would exceed IMG_WIDTH−1 it holds at IMG_WIDTH−1 and sets line_err.
- row saturates at all-ones and does not wrap.
- Config port:
  - cfg_ready = !cfg_pending.
  - cfg_valid && cfg_ready captures {cfg_p1, cfg_p2} into the shadow register and sets cfg_pending.
  - On a v_sync rising edge: p1/p2 ← shadow, and cfg_pending clears.
  - Capture and v_sync edge in the same cycle: the new values bypass the shadow straight into p1/p2, and cfg_pending stays 0.
  - Clamp on capture: if cfg_p2 < cfg_p1, p2 is stored as cfg_p1.
- All strobes are zero while in WAIT_FRAME.

## Timing
- Every output is registered. Strobes, row and col lag de_in by exactly 1 clk; the top level delays pixel data by 1 clk to match.
- de_half_ext stays high 1 cycle after de_half falls.
- Penalty change is visible on p1/p2 the cycle after the v_sync rising edge.
- Reset values:
  - p1 = P1_DEFAULT, p2 = P2_DEFAULT.
  - All strobes 0, row and col 0.
  - cfg_pending 0, cfg_ready 1, line_err 0.
  - FSM in WAIT_FRAME.
- rst mid-line aborts immediately. Outputs return to reset values on the next edge and the shadow contents are discarded.

## Structure
- Shared package `sgm_pkg`:
  - FSM state encoding.
  - Penalty width and default constants.
  - HALF_IMG_WIDTH and IMG_WIDTH defaults.
- One sub-module, `raster_tracker`: the FSM plus row/col counters and line_err.
- The penalty shadow/handshake logic and strobe decode live in the top.

## Test plan
- Reset, then v_sync, then 2 lines of 1280 de cycles:
  - row goes 0→1.
  - beg_horizontal pulses once per line at col 640.
  - beg_top stays high for cols 640–1279 of row 0 only.
  - beg_diag_r2l pulses at col 1279 of row 1.
- Check de_half falls and de_half_ext holds exactly 1 extra cycle, both 1 clk after de_in.
- Write cfg_p1=20, cfg_p2=120 mid-frame:
  - cfg_ready drops.
  - p1/p2 stay 15/100 until the next v_sync rising edge, then become 20/120.
  - cfg_ready rises again.
- Write cfg_p1=50, cfg_p2=30 on the same cycle as the v_sync rising edge: p1=50, p2=50 the next cycle, and cfg_pending stays 0.
- Drive a line of 1300 de cycles: col holds at 1279 and line_err sets, then clears at the next v_sync.
- Assert rst at col 700 of row 3: all outputs reset on the next edge, and de_in is ignored until a new v_sync.
